// File: rtl/hex_disp_ctrl.sv
// hex_disp_ctrl: four-digit seven-segment display controller with an
// Avalon-MM slave register interface.
//
// Registers: 0 DATA (four hex nibbles), 1 CTRL (blank / blink masks),
// 2 STATUS (blink phase), 3 reserved.
//
// Build option: define HEX_DISP_BLINK_EN to include the blink counter,
// the blink phase and the CTRL[7:4] blink mask. Without it the blink
// mask reads 0, writes to it are dropped and STATUS always reads 0.

module hex_disp_ctrl #(
  parameter int BLINK_DIV = 25000000  // clk cycles per blink half-period
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_CTRL   = 2'd1,
    ADDR_STATUS = 2'd2,
    ADDR_RSVD   = 2'd3
  } reg_addr_e;

  // All segment lines are active-low; this is every segment off.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Wide enough for the largest legal divider (2^26 - 1).
  localparam int CNT_W = 26;

  // Active-low segment pattern for one hex digit (bit0 = a ... bit6 = g).
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  reg_addr_e  addr;
  logic       wr_en;
  logic       rd_en;

  logic [15:0] data_q;
  logic [3:0]  blank_q;
  logic [3:0]  blink_mask;
  logic        blink_phase;

  logic [31:0]      rd_mux;
  logic [3:0][6:0]  seg_next;

  assign addr  = reg_addr_e'(address);
  assign wr_en = chipselect & write;
  assign rd_en = chipselect & read;

  // DATA and CTRL blank mask: written in the same cycle the strobe is seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      blank_q <= '0;
    end else if (wr_en) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge values of its inputs, independent of the
      // order the simulator evaluates processes in.
      if (addr == ADDR_DATA) data_q  <= writedata[15:0];
      if (addr == ADDR_CTRL) blank_q <= writedata[3:0];
    end
  end

`ifdef HEX_DISP_BLINK_EN

  logic [3:0]       blink_q;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase_q;
  logic             unused_wdata;

  // Bits above the CTRL byte and DATA halfword are write-ignored.
  assign unused_wdata = ^writedata[31:16];

  // CTRL blink mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q <= '0;
    end else if (wr_en && addr == ADDR_CTRL) begin
      blink_q <= writedata[7:4];
    end
  end

  // Free-running half-period counter; phase flips each time it wraps.
  // Register writes never touch it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase_q   <= ~phase_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_mask  = blink_q;
  assign blink_phase = phase_q;

`else

  logic unused_wdata;

  // Without the blink feature the blink-mask bits are dropped as well.
  assign unused_wdata = ^{writedata[31:16], writedata[7:4]};

  assign blink_mask  = 4'b0000;
  assign blink_phase = 1'b0;

`endif

  // Read mux over the register map; unmapped bits read as zero.
  always_comb begin
    // NOTE: defaulting every always_comb output first means no path leaves
    // it unassigned, so no latch can be inferred.
    rd_mux = '0;
    case (addr)
      ADDR_DATA:   rd_mux = {16'h0000, data_q};
      ADDR_CTRL:   rd_mux = {24'h000000, blink_mask, blank_q};
      ADDR_STATUS: rd_mux = {31'h0, blink_phase};
      ADDR_RSVD:   rd_mux = '0;
      default:     rd_mux = '0;
    endcase
  end

  // Read data register: captures pre-write register contents, then holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_mux;
    end
  end

  // Per-digit segment selection: blank beats blink, blink beats decode.
  always_comb begin
    seg_next = '0;
    for (int k = 0; k < 4; k++) begin
      if (blank_q[k]) begin
        seg_next[k] = SEG_OFF;
      end else if (blink_mask[k] && blink_phase) begin
        seg_next[k] = SEG_OFF;
      end else begin
        seg_next[k] = seg_decode(data_q[4*k +: 4]);
      end
    end
  end

  // Registered segment outputs, one cycle behind the register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex0 <= SEG_OFF;
      hex1 <= SEG_OFF;
      hex2 <= SEG_OFF;
      hex3 <= SEG_OFF;
    end else begin
      hex0 <= seg_next[0];
      hex1 <= seg_next[1];
      hex2 <= seg_next[2];
      hex3 <= seg_next[3];
    end
  end

endmodule

// File: doc/hex_disp_ctrl.md
HEX_DISP_CTRL -- requirements
Module: hex_disp_ctrl

Interface
REQ-001 The block SHALL have parameter BLINK_DIV, default 25000000, meaning clk cycles per blink half-period; legal range 2 to 2^26-1.
REQ-002 The block SHALL have port clk  input  1  system clock, with all logic on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-005 The block SHALL have port address  input  2  register index.
REQ-006 The block SHALL have port write  input  1  write strobe, qualified by chipselect.
REQ-007 The block SHALL have port writedata  input  32  write data.
REQ-008 The block SHALL have port read  input  1  read strobe, qualified by chipselect.
REQ-009 The block SHALL have port readdata  output  32  read data.
REQ-010 The block SHALL have ports hex0, hex1, hex2 and hex3  output  7  each, active-low segments, where bit0 is segment a and bit6 is segment g.

Function
REQ-011 The register map SHALL be as follows.
- 0: DATA[15:0], RW; nibble k drives hexk.
- 1: CTRL, RW; [3:0] blank mask, [7:4] blink mask, other bits write-ignored and read 0.
- 2: STATUS, RO; bit0 is the blink phase, other bits read 0.
- 3: reserved; reads 0, writes ignored.
REQ-012 A write SHALL take effect when chipselect and write are both high at a rising edge; the register updates on that edge.
REQ-013 The write path SHALL have no wait states; every write is accepted in one cycle.
REQ-014 Read data SHALL appear on readdata one cycle after chipselect and read are sampled high.
REQ-015 readdata SHALL hold its last value when no read is active.
REQ-016 During a read of DATA in the same cycle as a write to DATA, readdata SHALL return the pre-write value.
REQ-017 Each hexk SHALL be registered and SHALL reflect register state one cycle after the register update, giving write-to-segment latency 2 edges.
REQ-018 The decoder SHALL use the active-low patterns 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
REQ-019 A digit SHALL drive 7F (all segments off) when its blank bit is 1; blank takes priority over blink.
REQ-020 A blink counter SHALL count 0 to BLINK_DIV-1 and wrap to 0; the blink phase SHALL toggle on each wrap.
REQ-021 A digit SHALL drive 7F when its blink bit is 1 and the phase is 1; otherwise it SHALL show its decoded nibble.
REQ-022 The blink counter SHALL free-run regardless of register writes.
REQ-023 A CTRL write SHALL NOT reset the blink counter or phase.
REQ-024 Simultaneous chipselect, read and write SHALL be legal; both are served per REQ-012 to REQ-016.

Reset
REQ-025 While reset_n is low, the block SHALL hold DATA=0, CTRL=0, phase=0, counter=0, readdata=0, and hex0 to hex3 = 7F.
REQ-026 Reset assertion mid-operation SHALL take effect immediately, without a clock edge.
REQ-027 On the first rising edge after reset_n goes high, hex0 to hex3 SHALL become 40 (displaying 0000).

Configuration
REQ-028 When macro HEX_DISP_BLINK_EN is defined, the blink counter, phase and CTRL[7:4] SHALL be implemented as described above.
REQ-029 When HEX_DISP_BLINK_EN is undefined, the counter and phase SHALL not be implemented; CTRL[7:4] and STATUS bit0 SHALL read 0, and blink-mask writes SHALL have no effect.

Verification
REQ-030 Reset release, then idle 2 cycles -> hex0 to hex3 = 40; a read of each address returns 0.
REQ-031 Write DATA=0x0000A5F3 -> two edges later, hex0=30, hex1=0E, hex2=12, hex3=08; a read of DATA the next cycle returns 0x0000A5F3.
REQ-032 Write CTRL=0xFFFF0102 -> hex1=7F and the other digits are decoded; a CTRL read returns 0x00000002.
REQ-033 With BLINK_DIV=4, HEX_DISP_BLINK_EN defined and CTRL=0x11 -> hex0 stays 7F from the blank bit; STATUS bit0 toggles every 4 cycles.
REQ-034 With BLINK_DIV=4 and CTRL=0x10 -> hex0 alternates decoded/7F every 4 cycles; with the macro undefined, hex0 stays decoded.
REQ-035 Assert reset_n low between edges while blinking -> outputs go to 7F without a clock edge, and all registers read 0 after release.
